// File: rtl/cd_tx_ram_if.sv
// Host/tx-engine bus of the transmit frame buffer.
// The master side is the host plus the tx engine. The slave side is the buffer.
interface cd_tx_ram_if #(parameter int P_WIDTH = 2) ();
    logic [7:0]       wr_byte;
    logic [7:0]       wr_addr;
    logic             wr_en;
    logic [8:0]       wr_len;
    logic             switch;
    logic             switch_fail;
    logic [P_WIDTH:0] free_cnt;
    logic [7:0]       rd_addr;
    logic             rd_en;
    logic [7:0]       rd_byte;
    logic             pending;
    logic [8:0]       rd_len;
    logic             rd_done;
    logic             abort_all;

    modport master (
        output wr_byte, wr_addr, wr_en, wr_len, switch, rd_addr, rd_en, rd_done, abort_all,
        input  switch_fail, free_cnt, rd_byte, pending, rd_len
    );
    modport slave (
        input  wr_byte, wr_addr, wr_en, wr_len, switch, rd_addr, rd_en, rd_done, abort_all,
        output switch_fail, free_cnt, rd_byte, pending, rd_len
    );
endinterface

// File: rtl/cd_tx_ram.sv
// Transmit frame buffer. The host fills pages and commits them. The tx engine drains
// the committed pages in FIFO order, one 256-byte page per frame.
module cd_tx_ram #(
    parameter int P_WIDTH = 2
) (
    input logic          clk,
    input logic          reset,
    cd_tx_ram_if.slave   bus
);
    localparam int NPAGE = 2**P_WIDTH;
    localparam int AW    = P_WIDTH + 8;

    logic [P_WIDTH-1:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [NPAGE-1:0]   valid_q, valid_d;
    logic [8:0]         len_tbl_q [NPAGE];
    logic               wr_cancel_q, wr_cancel_d;
    logic               switch_fail_q, switch_fail_d;
    logic [P_WIDTH:0]   free_cnt_q, free_cnt_d;
    logic               wr_pend_q;
    logic [AW-1:0]      wr_waddr_q;
    logic [7:0]         wr_wdata_q;
    logic [7:0]         rd_byte_q;
    logic [7:0]         mem_q [0:(1<<AW)-1];

    logic wr_ok, len_ok, commit, release_pg;

    assign wr_ok      = bus.wr_en && !wr_cancel_q && !valid_q[wr_sel_q] && !bus.abort_all;
    assign len_ok     = (bus.wr_len != 9'd0) && (bus.wr_len <= 9'd256);
    // The commit test uses the valid bits from before any release in this cycle.
    assign commit     = bus.switch && !wr_cancel_q && !valid_q[wr_sel_q] && len_ok;
    assign release_pg = bus.rd_done && valid_q[rd_sel_q];

    always_comb begin
        logic [P_WIDTH:0] used;
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        valid_d       = valid_q;
        wr_cancel_d   = wr_cancel_q;
        switch_fail_d = bus.switch && !commit;
        used          = '0;
        if (bus.wr_en && valid_q[wr_sel_q]) wr_cancel_d = 1'b1;
        if (bus.switch)                     wr_cancel_d = 1'b0;
        if (release_pg) begin
            valid_d[rd_sel_q] = 1'b0;
            rd_sel_d          = rd_sel_q + 1'b1;
        end
        if (commit) begin
            valid_d[wr_sel_q] = 1'b1;
            wr_sel_d          = wr_sel_q + 1'b1;
        end
        for (int i = 0; i < NPAGE; i++) used = used + (P_WIDTH+1)'(valid_d[i]);
        free_cnt_d = (P_WIDTH+1)'(NPAGE) - used;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.abort_all) begin
            wr_sel_q      <= '0;
            rd_sel_q      <= '0;
            valid_q       <= '0;
            wr_cancel_q   <= 1'b0;
            switch_fail_q <= 1'b0;
            free_cnt_q    <= (P_WIDTH+1)'(NPAGE);
            wr_pend_q     <= 1'b0;
        end else begin
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            valid_q       <= valid_d;
            wr_cancel_q   <= wr_cancel_d;
            switch_fail_q <= switch_fail_d;
            free_cnt_q    <= free_cnt_d;
            wr_pend_q     <= wr_ok;
        end
    end

    // The write page is captured with the byte, so a commit right after the last
    // write still lands that byte in the committed page.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            wr_waddr_q <= {wr_sel_q, bus.wr_addr};
            wr_wdata_q <= bus.wr_byte;
        end
        if (wr_pend_q) mem_q[wr_waddr_q] <= wr_wdata_q;
        if (bus.rd_en) rd_byte_q <= mem_q[{rd_sel_q, bus.rd_addr}];
        if (!reset && !bus.abort_all && commit) len_tbl_q[wr_sel_q] <= bus.wr_len;
    end

    assign bus.switch_fail = switch_fail_q;
    assign bus.free_cnt    = free_cnt_q;
    assign bus.rd_byte     = rd_byte_q;
    assign bus.pending     = valid_q[rd_sel_q];
    assign bus.rd_len      = len_tbl_q[rd_sel_q];
endmodule

// File: tb/tb_cd_tx_ram.sv
// Directed checks of the tx frame buffer: commit, full, wrap, bad lengths and abort.
module tb_cd_tx_ram;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    cd_tx_ram_if #(.P_WIDTH(2)) bus ();
    cd_tx_ram #(.P_WIDTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] fb(input logic [7:0] seed, input int i);
        return seed + 8'(i * 7);
    endfunction

    task automatic wr(input int addr, input logic [7:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = 8'(addr); bus.wr_byte = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic write_frame(input int len, input logic [7:0] seed);
        for (int i = 0; i < len; i++) wr(i, fb(seed, i));
    endtask

    task automatic commit(input int len, output logic fail);
        bus.switch = 1'b1; bus.wr_len = 9'(len);
        tick();
        bus.switch = 1'b0;
        fail = bus.switch_fail;
    endtask

    task automatic rd(input int addr, output logic [7:0] data);
        bus.rd_en = 1'b1; bus.rd_addr = 8'(addr);
        tick();
        bus.rd_en = 1'b0;
        data = bus.rd_byte;
    endtask

    task automatic release_head();
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
    endtask

    task automatic read_frame(input string tag, input int len, input logic [7:0] seed);
        logic [7:0] b;
        chk({tag, " pending"}, 32'(bus.pending), 32'd1);
        chk({tag, " rd_len"}, 32'(bus.rd_len), 32'(len));
        for (int i = 0; i < len; i++) begin
            rd(i, b);
            chk({tag, " byte"}, 32'(b), 32'(fb(seed, i)));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    int         lens [6] = '{1, 256, 17, 3, 9, 200};
    logic [7:0] seeds[6] = '{8'h13, 8'h27, 8'h3B, 8'h4F, 8'h63, 8'h77};

    initial begin
        logic       f;
        logic [7:0] b;
        bus.wr_byte = '0; bus.wr_addr = '0; bus.wr_en = 1'b0; bus.wr_len = '0;
        bus.switch = 1'b0; bus.rd_addr = '0; bus.rd_en = 1'b0; bus.rd_done = 1'b0;
        bus.abort_all = 1'b0;
        do_reset();
        chk("rst pending", 32'(bus.pending), 32'd0);
        chk("rst free", 32'(bus.free_cnt), 32'd4);
        chk("rst sfail", 32'(bus.switch_fail), 32'd0);

        // Single frame.
        for (int i = 0; i < 5; i++) wr(i, 8'hA0 + 8'(i));
        commit(5, f);
        chk("t1 sfail", 32'(f), 32'd0);
        chk("t1 pending", 32'(bus.pending), 32'd1);
        chk("t1 rd_len", 32'(bus.rd_len), 32'd5);
        chk("t1 free", 32'(bus.free_cnt), 32'd3);
        rd(2, b);
        chk("t1 byte2", 32'(b), 32'hA2);

        // Fill the buffer, then a fifth frame is rejected.
        for (int k = 1; k < 4; k++) begin
            write_frame(2, 8'h50 + 8'(k));
            commit(2, f);
            chk("t2 commit", 32'(f), 32'd0);
        end
        chk("t2 free full", 32'(bus.free_cnt), 32'd0);
        write_frame(2, 8'hEE);
        commit(2, f);
        chk("t2 sfail", 32'(f), 32'd1);
        tick();
        chk("t2 sfail pulse", 32'(bus.switch_fail), 32'd0);
        rd(0, b);
        chk("t2 head byte0", 32'(b), 32'hA0);
        rd(4, b);
        chk("t2 head byte4", 32'(b), 32'hA4);

        // Full buffer: a switch in the same cycle as rd_done fails, and the retry succeeds.
        bus.switch = 1'b1; bus.wr_len = 9'd1; bus.rd_done = 1'b1;
        tick();
        bus.switch = 1'b0; bus.rd_done = 1'b0;
        chk("t3 sfail", 32'(bus.switch_fail), 32'd1);
        chk("t3 free", 32'(bus.free_cnt), 32'd1);
        chk("t3 rd_len", 32'(bus.rd_len), 32'd2);
        commit(4, f);
        chk("t3 retry", 32'(f), 32'd0);
        chk("t3 free2", 32'(bus.free_cnt), 32'd0);
        rd(1, b);
        chk("t3 page1 byte", 32'(b), 32'(fb(8'h51, 1)));

        // Six frames through four pages: order is preserved across the wrap.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            write_frame(lens[k], seeds[k]);
            commit(lens[k], f);
            chk("t4 commit", 32'(f), 32'd0);
        end
        read_frame("t4 f0", lens[0], seeds[0]); release_head();
        write_frame(lens[4], seeds[4]); commit(lens[4], f);
        chk("t4 commit4", 32'(f), 32'd0);
        read_frame("t4 f1", lens[1], seeds[1]); release_head();
        write_frame(lens[5], seeds[5]); commit(lens[5], f);
        chk("t4 commit5", 32'(f), 32'd0);
        for (int k = 2; k < 6; k++) begin
            read_frame($sformatf("t4 f%0d", k), lens[k], seeds[k]);
            release_head();
        end
        chk("t4 empty", 32'(bus.pending), 32'd0);
        chk("t4 free", 32'(bus.free_cnt), 32'd4);

        // Illegal lengths.
        commit(0, f);
        chk("t5 len0", 32'(f), 32'd1);
        commit(257, f);
        chk("t5 len257", 32'(f), 32'd1);
        chk("t5 free", 32'(bus.free_cnt), 32'd4);
        chk("t5 pending", 32'(bus.pending), 32'd0);

        // Abort with a same-cycle switch.
        do_reset();
        write_frame(2, 8'h11); commit(2, f);
        write_frame(2, 8'h22); commit(2, f);
        chk("t6 free2", 32'(bus.free_cnt), 32'd2);
        wr(0, 8'h99);
        bus.abort_all = 1'b1; bus.switch = 1'b1; bus.wr_len = 9'd1;
        tick();
        bus.abort_all = 1'b0; bus.switch = 1'b0;
        chk("t6 pending", 32'(bus.pending), 32'd0);
        chk("t6 free", 32'(bus.free_cnt), 32'd4);
        chk("t6 sfail", 32'(bus.switch_fail), 32'd0);
        tick();
        chk("t6 sfail2", 32'(bus.switch_fail), 32'd0);
        write_frame(3, 8'h5C); commit(3, f);
        chk("t6 commit", 32'(f), 32'd0);
        chk("t6 free3", 32'(bus.free_cnt), 32'd3);
        read_frame("t6 page0", 3, 8'h5C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
